ex_commit_stage: RTL and testbench
==================================

Name: ex_commit_stage

Overview:
- Pipeline stage directly downstream of the execute ALU. Registers the ALU result and CCR flags with opcode/funct3/rd/PC context.
- Resolves conditional branches and jumps into a one-cycle PC redirect, and discards wrong-path shadow instructions.
- Drives the register-file writeback port through a valid/ready handshake and keeps a retired-instruction counter.

Parameters:
SHADOW_DEPTH, 1, number of accepted instructions discarded after a taken branch/jump (0..7)
XLEN, 32, datapath width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept this cycle
opcode  input  7  instruction opcode (same encoding as ALU)
funct3  input  3  instruction funct3
rd  input  5  destination register index
pc  input  XLEN  instruction PC
imm  input  XLEN  decoded immediate (sign-extended)
rs1_val  input  XLEN  rs1 operand (JALR base)
alu_result  input  XLEN  ALU Result
ccr_flags  input  6  ALU CCR, bits [5:0] = EQ|NE|LT|GE|LTU|GEU
wb_valid  output  1  writeback entry valid
wb_ready  input  1  register file accepts writeback
wb_we  output  1  write enable for the held entry
wb_rd  output  5  writeback register index
wb_data  output  XLEN  writeback data
redirect_valid  output  1  one-cycle PC redirect pulse
redirect_pc  output  XLEN  redirect target
illegal_insn  output  1  one-cycle pulse for an unsupported opcode/funct3
retired_count  output  32  committed instruction count

Behaviour:
- Reset (rst_n=0 at a clock edge): wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, redirect_valid=0, redirect_pc=0, illegal_insn=0, retired_count=0, shadow counter=0. Reset mid-transfer drops the held entry and any pending shadow.
- in_ready = !wb_valid || wb_ready. Accept = in_valid && in_ready. Latency is 1 cycle from accept to wb_valid.
- wb_valid, once set, holds with stable wb_rd/wb_data/wb_we until a cycle with wb_ready=1. Accept and drain in the same cycle replaces the entry with no bubble.
- Shadow: if the shadow counter is nonzero on accept, the instruction is dropped. No wb, no redirect, no illegal pulse, no retire. The counter decrements.
- Classification of non-dropped accepts:
  - R 0110011, I 0010011, LUI 0110111, AUIPC 0010111: wb_we = (rd!=0), wb_data = alu_result.
  - JAL 1101111: wb_data = alu_result (PC+4), wb_we = (rd!=0). Taken, target = pc+imm.
  - JALR 1100111: wb_data = alu_result, wb_we = (rd!=0). Taken, target = (rs1_val+imm) & ~1.
  - BRANCH 1100011, wb_we=0, target = pc+imm. Taken condition by funct3:
    - 000: EQ = ccr[5]
    - 001: !ccr[5]. The NE bit ccr[4] is ignored.
    - 100: ccr[3]
    - 101: ccr[2]
    - 110: ccr[1]
    - 111: ccr[0]
    - 010/011: illegal, not taken.
  - Any other opcode: illegal. wb_valid is still set with wb_we=0, so the entry retires as a no-op.
- Taken: redirect_valid=1 and redirect_pc=target in the cycle after accept, for exactly one cycle, independent of wb_ready. The shadow counter loads SHADOW_DEPTH in the same edge.
- illegal_insn pulses one cycle, the cycle after accept.
- retired_count increments by 1 on each edge where wb_valid && wb_ready, and wraps 0xFFFFFFFF -> 0.
- Address arithmetic is modulo 2^XLEN. Overflow is ignored.
- A taken instruction inside the shadow is dropped, so it produces no nested redirect.

Test Plan:
- Reset: hold rst_n=0 two cycles while in_valid=1 -> all outputs 0, no accept side-effects. Release -> in_ready=1.
- ADD: opcode=0110011, rd=5, alu_result=0x0000_000A, wb_ready=1 -> next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0xA, retired_count=1. Same with rd=0 -> wb_we=0, retired_count still increments.
- Backpressure: wb_ready=0 for 3 cycles with two back-to-back inputs -> the first entry is held stable, in_ready=0 and the second is not accepted. wb_ready=1 -> both retire in order, no bubble.
- BNE: opcode=1100011, funct3=001, pc=0x100, imm=0x20, ccr=6'b000101 -> redirect_valid pulse with redirect_pc=0x120. The next accepted instruction (ADDI rd=3) is dropped: no wb, retired_count unchanged. The following instruction writes back.
- JALR: rs1_val=0x2003, imm=0x4, alu_result=0x108, rd=1 -> redirect_pc=0x2006, wb_data=0x108, wb_rd=1.
- Illegal: opcode=1100011 funct3=010, then opcode=0000000 -> illegal_insn pulses twice, no redirect, both retire with wb_we=0. Preload retired_count=0xFFFFFFFF via retires -> next retire wraps to 0.

Source files
------------

// File: rtl/ex_commit_stage.sv
// ex_commit_stage: registers the execute result, resolves branches/jumps into a
// one-cycle redirect, squashes wrong-path shadow instructions, and drives the
// register-file writeback handshake plus a retired-instruction counter.
module ex_commit_stage #(
  parameter int SHADOW_DEPTH = 1,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] alu_result,
  input  logic [5:0]      ccr_flags,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            illegal_insn,
  output logic [31:0]     retired_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic            wb_valid_q, wb_valid_d;
  logic            wb_we_q, wb_we_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            illegal_q, illegal_d;
  logic [31:0]     retired_q, retired_d;
  logic [2:0]      shadow_q, shadow_d;

  logic            accept, drop, live;
  logic            dec_we, dec_taken, dec_illegal;
  logic [XLEN-1:0] dec_target;
  logic [XLEN-1:0] jalr_sum;

  // NE is redundant with !EQ; BNE is resolved from EQ alone.
  logic unused_ne;
  assign unused_ne = ccr_flags[4];

  assign in_ready = !wb_valid_q || wb_ready;
  assign accept   = in_valid && in_ready;
  assign drop     = accept && (shadow_q != 3'd0);
  assign live     = accept && (shadow_q == 3'd0);
  assign jalr_sum = rs1_val + imm;

  // Decode: writeback enable, branch resolution, target and legality.
  always_comb begin
    dec_we      = 1'b0;
    dec_taken   = 1'b0;
    dec_illegal = 1'b0;
    dec_target  = pc + imm;
    case (opcode)
      OP_R, OP_I, OP_LUI, OP_AUIPC: dec_we = (rd != 5'd0);
      OP_JAL: begin
        dec_we    = (rd != 5'd0);
        dec_taken = 1'b1;
      end
      OP_JALR: begin
        dec_we     = (rd != 5'd0);
        dec_taken  = 1'b1;
        dec_target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  dec_taken = ccr_flags[5];
          3'b001:  dec_taken = !ccr_flags[5];
          3'b100:  dec_taken = ccr_flags[3];
          3'b101:  dec_taken = ccr_flags[2];
          3'b110:  dec_taken = ccr_flags[1];
          3'b111:  dec_taken = ccr_flags[0];
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Next-state: writeback slot, redirect/illegal pulses, shadow and retire count.
  always_comb begin
    wb_valid_d       = wb_valid_q;
    wb_we_d          = wb_we_q;
    wb_rd_d          = wb_rd_q;
    wb_data_d        = wb_data_q;
    redirect_valid_d = live && dec_taken;
    redirect_pc_d    = redirect_pc_q;
    illegal_d        = live && dec_illegal;
    shadow_d         = shadow_q;
    retired_d        = retired_q + 32'(wb_valid_q && wb_ready);
    if (wb_ready) wb_valid_d = 1'b0;
    if (live) begin
      // Fill and drain in the same cycle simply overwrites the slot.
      wb_valid_d = 1'b1;
      wb_we_d    = dec_we;
      wb_rd_d    = rd;
      wb_data_d  = alu_result;
    end
    if (live && dec_taken) begin
      redirect_pc_d = dec_target;
      shadow_d      = 3'(SHADOW_DEPTH);
    end else if (drop) begin
      shadow_d = shadow_q - 3'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_q       <= 1'b0;
      wb_we_q          <= 1'b0;
      wb_rd_q          <= 5'd0;
      wb_data_q        <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      illegal_q        <= 1'b0;
      retired_q        <= 32'd0;
      shadow_q         <= 3'd0;
    end else begin
      wb_valid_q       <= wb_valid_d;
      wb_we_q          <= wb_we_d;
      wb_rd_q          <= wb_rd_d;
      wb_data_q        <= wb_data_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      illegal_q        <= illegal_d;
      retired_q        <= retired_d;
      shadow_q         <= shadow_d;
    end
  end

  assign wb_valid       = wb_valid_q;
  assign wb_we          = wb_we_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign illegal_insn   = illegal_q;
  assign retired_count  = retired_q;

endmodule

// File: tb/tb_ex_commit_stage.sv
// tb_ex_commit_stage: scoreboard bench for the commit stage.
module tb_ex_commit_stage;
  localparam int SD   = 1;
  localparam int XLEN = 32;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] JR = 7'b1100111;
  localparam logic [6:0] BR = 7'b1100011;

  logic            clk = 1'b0;
  logic            rst_n, in_valid, in_ready, wb_valid, wb_ready, wb_we;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd, wb_rd;
  logic [XLEN-1:0] pc, imm, rs1_val, alu_result, wb_data, redirect_pc;
  logic [5:0]      ccr_flags;
  logic            redirect_valid, illegal_insn;
  logic [31:0]     retired_count;

  always #5 clk = ~clk;

  ex_commit_stage #(.SHADOW_DEPTH(SD), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .rd(rd), .pc(pc), .imm(imm),
    .rs1_val(rs1_val), .alu_result(alu_result), .ccr_flags(ccr_flags),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .illegal_insn(illegal_insn), .retired_count(retired_count)
  );

  typedef struct {logic we; logic [4:0] rd; logic [31:0] data;} wb_t;
  typedef struct {int due; logic [31:0] pc;} rdr_t;

  wb_t   wbq[$];
  int    wb_due[$];
  rdr_t  rq[$];
  int    ill_due[$];

  int          total = 0, bad = 0, cyc = 0, sh = 0;
  logic        chk_en = 1'b0;
  logic [31:0] exp_ret = 32'd0;
  logic        hold_prev = 1'b0, hold_we;
  logic [4:0]  hold_rd;
  logic [31:0] hold_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model of one accepted instruction; fills the scoreboard.
  task automatic model_accept(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                              input logic [31:0] p, input logic [31:0] im, input logic [31:0] rs1,
                              input logic [31:0] alu, input logic [5:0] cc);
    wb_t  e;
    logic tk, il;
    logic [31:0] tg;
    if (sh > 0) begin
      sh--;
      return;
    end
    tk = 1'b0; il = 1'b0; tg = p + im;
    e.we = 1'b0; e.rd = r; e.data = alu;
    if (op == R || op == I || op == 7'b0110111 || op == 7'b0010111) e.we = (r != 0);
    else if (op == JL) begin e.we = (r != 0); tk = 1'b1; end
    else if (op == JR) begin e.we = (r != 0); tk = 1'b1; tg = (rs1 + im) & 32'hFFFF_FFFE; end
    else if (op == BR) begin
      if (f3 == 3'd0)      tk = cc[5];
      else if (f3 == 3'd1) tk = ~cc[5];
      else if (f3 == 3'd4) tk = cc[3];
      else if (f3 == 3'd5) tk = cc[2];
      else if (f3 == 3'd6) tk = cc[1];
      else if (f3 == 3'd7) tk = cc[0];
      else il = 1'b1;
    end else il = 1'b1;
    wbq.push_back(e);
    wb_due.push_back(cyc + 1);
    if (tk) begin rq.push_back('{cyc + 1, tg}); sh = SD; end
    if (il) ill_due.push_back(cyc + 1);
  endtask

  // Drive one instruction from a negedge until accepted (bounded).
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                      input logic [31:0] p, input logic [31:0] im, input logic [31:0] rs1,
                      input logic [31:0] alu, input logic [5:0] cc);
    int w;
    bit done;
    w = 0; done = 1'b0;
    in_valid = 1'b1; opcode = op; funct3 = f3; rd = r; pc = p; imm = im;
    rs1_val = rs1; alu_result = alu; ccr_flags = cc;
    while (!done) begin
      #1;
      if (in_ready) begin
        model_accept(op, f3, r, p, im, rs1, alu, cc);
        done = 1'b1;
      end else if (w >= 50) begin
        chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        done = 1'b1;
      end
      @(negedge clk);
      w++;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: samples mid-cycle, checks pulses, hold stability, writeback order, count.
  initial forever begin
    @(negedge clk);
    #2;
    if (chk_en) begin
      while (wb_due.size() > 0 && wb_due[0] <= cyc) begin
        chk("wb_latency", wb_valid, 1'b1);
        void'(wb_due.pop_front());
      end
      if (hold_prev) begin
        chk("hold_valid", wb_valid, 1'b1);
        chk("hold_we", wb_we, hold_we);
        chk("hold_rd", wb_rd, hold_rd);
        chk("hold_data", wb_data, hold_data);
      end
      hold_prev = wb_valid && !wb_ready;
      hold_we = wb_we; hold_rd = wb_rd; hold_data = wb_data;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        chk("redir_valid", redirect_valid, 1'b1);
        chk("redir_pc", redirect_pc, rq[0].pc);
        void'(rq.pop_front());
      end else chk("redir_valid", redirect_valid, 1'b0);
      if (ill_due.size() > 0 && ill_due[0] <= cyc) begin
        chk("illegal", illegal_insn, 1'b1);
        void'(ill_due.pop_front());
      end else chk("illegal", illegal_insn, 1'b0);
      chk("retired", retired_count, exp_ret);
      if (wb_valid && wb_ready) begin
        if (wbq.size() == 0) chk("wb_extra", 64'd1, 64'd0);
        else begin
          wb_t e;
          e = wbq.pop_front();
          chk("wb_we", wb_we, e.we);
          if (e.we) begin
            chk("wb_rd", wb_rd, e.rd);
            chk("wb_data", wb_data, e.data);
          end
        end
        exp_ret = exp_ret + 32'd1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; opcode = R; funct3 = 3'd0; rd = 5'd5; pc = '0;
    imm = '0; rs1_val = '0; alu_result = 32'h55; ccr_flags = 6'd0; wb_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_we", wb_we, 1'b0);
    chk("rst_wb_rd", wb_rd, 5'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_redir_v", redirect_valid, 1'b0);
    chk("rst_redir_pc", redirect_pc, 32'd0);
    chk("rst_illegal", illegal_insn, 1'b0);
    chk("rst_retired", retired_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_no_accept", wb_valid, 1'b0);
    @(negedge clk);
    chk_en = 1'b1;

    // Plain ALU writebacks, including rd=0.
    send(R, 3'd0, 5'd5, 32'h0, 32'h0, 32'h0, 32'hA, 6'd0);
    send(R, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h7, 6'd0);
    idle(3);
    chk("ret_after_add", retired_count, 32'd2);

    // Backpressure: first entry held, second waits, then both retire back to back.
    wb_ready = 1'b0;
    send(I, 3'd0, 5'd7, 32'h0, 32'h0, 32'h0, 32'h77, 6'd0);
    fork
      send(R, 3'd0, 5'd8, 32'h0, 32'h0, 32'h0, 32'h88, 6'd0);
      begin
        for (int k = 0; k < 3; k++) begin
          #2 chk("bp_in_ready", in_ready, 1'b0);
          @(negedge clk);
        end
        wb_ready = 1'b1;
      end
    join
    idle(3);

    // BNE taken via !EQ (NE bit clear), shadow drops the next instruction.
    send(BR, 3'd1, 5'd0, 32'h100, 32'h20, 32'h0, 32'h0, 6'b000101);
    send(I, 3'd0, 5'd3, 32'h0, 32'h0, 32'h0, 32'h33, 6'd0);
    send(I, 3'd0, 5'd4, 32'h0, 32'h0, 32'h0, 32'h44, 6'd0);
    idle(2);

    // JALR target with low bit cleared, then JAL with negative offset.
    send(JR, 3'd0, 5'd1, 32'h0, 32'h4, 32'h2003, 32'h108, 6'd0);
    send(R, 3'd0, 5'd9, 32'h0, 32'h0, 32'h0, 32'h99, 6'd0);
    send(JL, 3'd0, 5'd2, 32'h200, 32'hFFFF_FF00, 32'h0, 32'h204, 6'd0);
    send(R, 3'd0, 5'd10, 32'h0, 32'h0, 32'h0, 32'hAA, 6'd0);
    // BEQ not taken, BLTU taken.
    send(BR, 3'd0, 5'd0, 32'h300, 32'h8, 32'h0, 32'h0, 6'b000000);
    send(BR, 3'd6, 5'd0, 32'h300, 32'h8, 32'h0, 32'h0, 6'b000010);
    send(R, 3'd0, 5'd11, 32'h0, 32'h0, 32'h0, 32'hBB, 6'd0);
    send(R, 3'd0, 5'd12, 32'h0, 32'h0, 32'h0, 32'hCC, 6'd0);
    // Illegal branch funct3 (all flags set, must not redirect) and unknown opcode.
    send(BR, 3'd2, 5'd0, 32'h400, 32'h10, 32'h0, 32'h0, 6'b111111);
    send(7'b0000000, 3'd0, 5'd13, 32'h0, 32'h0, 32'h0, 32'hDD, 6'd0);
    idle(3);

    // Retire counter wrap.
    force dut.retired_q = 32'hFFFF_FFFF;
    exp_ret = 32'hFFFF_FFFF;
    #1 release dut.retired_q;
    @(negedge clk);
    send(R, 3'd0, 5'd6, 32'h0, 32'h0, 32'h0, 32'h66, 6'd0);
    idle(3);
    chk("ret_wrap", retired_count, 32'd0);

    chk("wbq_empty", wbq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    chk("ill_empty", ill_due.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
